// File: rtl/ins_fetch.sv
// Instruction fetch: one outstanding icache request, static/predicted next-PC, valid/ready hand-off to decode.
// Latency: request 1 cycle after FETCH; decode output registered on the response edge; flush redirects pc next cycle.
module ins_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_inst,
   output logic [31:0] pred_pc,
   input  logic        pred_jump,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc,
   output logic        dec_pred_jump,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc
);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        req_valid_nxt;
   logic [31:0] req_addr_nxt;
   logic        dvalid_nxt;
   logic [31:0] dinst_nxt;
   logic [31:0] dpc_nxt;
   logic        dpj_nxt;

   logic [31:0] j_imm;
   logic [31:0] b_imm;
   logic [31:0] next_pc;
   logic        next_pj;

   assign pred_pc = pc;

   assign j_imm = {{11{ic_resp_inst[31]}}, ic_resp_inst[31], ic_resp_inst[19:12],
                   ic_resp_inst[20], ic_resp_inst[30:21], 1'b0};
   assign b_imm = {{19{ic_resp_inst[31]}}, ic_resp_inst[31], ic_resp_inst[7],
                   ic_resp_inst[30:25], ic_resp_inst[11:8], 1'b0};

   // Compressed words are never predicted, even if they encode a branch.
   always_comb begin
      next_pc = pc + 32'd4;
      next_pj = 1'b0;
      if (ic_resp_inst[1:0] != 2'b11) begin
         next_pc = pc + 32'd2;
      end else if (ic_resp_inst[6:0] == OP_JAL) begin
         next_pc = pc + j_imm;
         next_pj = 1'b1;
      end else if (ic_resp_inst[6:0] == OP_BRANCH && pred_jump) begin
         next_pc = pc + b_imm;
         next_pj = 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_valid_nxt = ic_req_valid;
      req_addr_nxt  = ic_req_addr;
      dvalid_nxt    = dec_valid;
      dinst_nxt     = dec_inst;
      dpc_nxt       = dec_pc;
      dpj_nxt       = dec_pred_jump;

      if (flush_valid) begin
         pc_nxt     = flush_pc;
         dvalid_nxt = 1'b0;
      end

      case (state)
         FETCH: begin
            if (!flush_valid) begin
               req_valid_nxt = 1'b1;
               req_addr_nxt  = pc;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            if (flush_valid) begin
               req_valid_nxt = 1'b0;
               state_nxt     = ic_resp_valid ? FETCH : DRAIN;
            end else if (ic_resp_valid) begin
               dinst_nxt     = ic_resp_inst;
               dpc_nxt       = pc;
               dpj_nxt       = next_pj;
               dvalid_nxt    = 1'b1;
               req_valid_nxt = 1'b0;
               pc_nxt        = next_pc;
               state_nxt     = HOLD;
            end
         end
         HOLD: begin
            if (flush_valid) begin
               state_nxt = FETCH;
            end else if (dec_ready) begin
               dvalid_nxt    = 1'b0;
               req_valid_nxt = 1'b1;
               req_addr_nxt  = pc;
               state_nxt     = WAIT;
            end
         end
         DRAIN: begin
            // The stale response for the abandoned request must be swallowed before refetching.
            req_valid_nxt = 1'b0;
            if (ic_resp_valid) begin
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         ic_req_valid  <= 1'b0;
         ic_req_addr   <= RESET_PC;
         dec_valid     <= 1'b0;
         dec_inst      <= 32'd0;
         dec_pc        <= 32'd0;
         dec_pred_jump <= 1'b0;
      end else if (rdy_in) begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         ic_req_valid  <= req_valid_nxt;
         ic_req_addr   <= req_addr_nxt;
         dec_valid     <= dvalid_nxt;
         dec_inst      <= dinst_nxt;
         dec_pc        <= dpc_nxt;
         dec_pred_jump <= dpj_nxt;
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: behavioural icache, scoreboarded request and decode streams, directed redirect scenarios.
module tb_ins_fetch;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        ic_req_valid;
   logic [31:0] ic_req_addr;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_inst;
   logic [31:0] pred_pc;
   logic        pred_jump;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_pred_jump;
   logic        flush_valid;
   logic [31:0] flush_pc;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pj;
   } dec_t;

   logic [31:0] exp_req[$];
   dec_t        exp_dec[$];
   logic [31:0] imem[logic [31:0]];
   int          vectors = 0;
   int          fails = 0;
   int          granted = 0;
   int          accepted = 0;
   int          lat = 1;
   logic        pj = 1'b0;

   assign pred_jump = pj;

   ins_fetch #(.RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
      .pred_pc(pred_pc), .pred_jump(pred_jump),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
      .dec_pc(dec_pc), .dec_pred_jump(dec_pred_jump),
      .flush_valid(flush_valid), .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (imem.exists(a)) return imem[a];
      return 32'h0000_0013;
   endfunction

   // icache: answers each new request `lat` cycles after seeing it, one-cycle pulse.
   initial begin
      logic [31:0] a;
      ic_resp_valid = 1'b0;
      ic_resp_inst  = 32'd0;
      forever begin
         @(posedge clk_in); #1;
         if (ic_req_valid) begin
            a = ic_req_addr;
            repeat (lat) @(posedge clk_in);
            #1;
            ic_resp_valid = 1'b1;
            ic_resp_inst  = word_at(a);
            @(posedge clk_in); #1;
            ic_resp_valid = 1'b0;
            while (ic_req_valid) begin
               @(posedge clk_in); #1;
            end
         end
      end
   end

   // Request monitor: every rising ic_req_valid must match the next expected address.
   initial begin
      logic prev = 1'b0;
      logic [31:0] e;
      forever begin
         @(posedge clk_in); #1;
         if (ic_req_valid && !prev) begin
            if (exp_req.size() == 0) begin
               chk("unexpected_req", ic_req_addr, 32'hFFFF_FFFF);
            end else begin
               e = exp_req.pop_front();
               chk("req_addr", ic_req_addr, e);
            end
         end
         prev = ic_req_valid;
      end
   end

   // Decode side: grants acceptances one by one and checks each accepted instruction.
   initial begin
      dec_t e;
      dec_ready = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         dec_ready = (accepted < granted);
         if (dec_valid && dec_ready) begin
            accepted++;
            if (exp_dec.size() == 0) begin
               chk("unexpected_dec", dec_pc, 32'hFFFF_FFFF);
            end else begin
               e = exp_dec.pop_front();
               chk("dec_pc", dec_pc, e.pc);
               chk("dec_inst", dec_inst, e.inst);
               chk("dec_pred_jump", {31'd0, dec_pred_jump}, {31'd0, e.pj});
            end
         end
      end
   end

   task automatic push_dec(input logic [31:0] inst, input logic [31:0] pc, input logic p);
      dec_t d;
      d.inst = inst; d.pc = pc; d.pj = p;
      exp_dec.push_back(d);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_req.size() != 0 || exp_dec.size() != 0) && n < 300) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 300) chk("timeout_idle", exp_req.size() + exp_dec.size(), 0);
      repeat (8) @(negedge clk_in);
   endtask

   task automatic wait_req(input logic [31:0] a);
      int n = 0;
      while (!(ic_req_valid && ic_req_addr == a) && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      if (n >= 100) chk("timeout_req", ic_req_addr, a);
   endtask

   task automatic do_flush(input logic [31:0] a);
      @(negedge clk_in);
      flush_valid = 1'b1;
      flush_pc    = a;
      @(negedge clk_in);
      flush_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst_in      = 1'b0;
      rdy_in      = 1'b1;
      flush_valid = 1'b0;
      flush_pc    = 32'd0;
      imem[32'h08] = 32'h0000_0001;
      imem[32'h10] = 32'h0200_006F;
      imem[32'h40] = 32'hFE00_0CE3;

      #3;
      chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
      chk("rst_req_addr", ic_req_addr, 32'd0);
      chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
      chk("rst_dec_inst", dec_inst, 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_pred_pc", pred_pc, 32'd0);

      // Sequential run, compressed word at 0x8.
      foreach (exp_req[i]) exp_req.delete(i);
      exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
      exp_req.push_back(32'hA); exp_req.push_back(32'hE);
      push_dec(32'h13, 32'h0, 1'b0); push_dec(32'h13, 32'h4, 1'b0);
      push_dec(32'h1, 32'h8, 1'b0);  push_dec(32'h13, 32'hA, 1'b0);
      granted = 4;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      chk("first_req_1cycle", {31'd0, ic_req_valid}, 32'd1);
      wait_idle();

      // JAL +0x20 at 0x10.
      exp_req.push_back(32'h10); exp_req.push_back(32'h30);
      push_dec(32'h0200_006F, 32'h10, 1'b1);
      do_flush(32'h10);
      granted++;
      wait_idle();

      // BEQ -8 at 0x40, predicted taken then not taken.
      pj = 1'b1;
      exp_req.push_back(32'h40); exp_req.push_back(32'h38);
      push_dec(32'hFE00_0CE3, 32'h40, 1'b1);
      do_flush(32'h40);
      granted++;
      wait_idle();
      pj = 1'b0;
      exp_req.push_back(32'h40); exp_req.push_back(32'h44);
      push_dec(32'hFE00_0CE3, 32'h40, 1'b0);
      do_flush(32'h40);
      granted++;
      wait_idle();

      // Decode stall: outputs stable, no request while held.
      exp_req.push_back(32'h100); exp_req.push_back(32'h104);
      push_dec(32'h13, 32'h100, 1'b0);
      do_flush(32'h100);
      n = 0;
      while (!dec_valid && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         chk("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
         chk("stall_dec_inst", dec_inst, 32'h13);
         chk("stall_dec_pc", dec_pc, 32'h100);
         chk("stall_no_req", {31'd0, ic_req_valid}, 32'd0);
      end
      granted++;
      wait_idle();

      // Flush while waiting; stale response arrives two cycles later.
      lat = 2;
      exp_req.push_back(32'h180); exp_req.push_back(32'h200); exp_req.push_back(32'h204);
      push_dec(32'h13, 32'h200, 1'b0);
      do_flush(32'h180);
      wait_req(32'h180);
      flush_valid = 1'b1;
      flush_pc    = 32'h200;
      @(negedge clk_in);
      flush_valid = 1'b0;
      chk("drain_req_low", {31'd0, ic_req_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_dec_valid", {31'd0, dec_valid}, 32'd0);
         @(negedge clk_in);
      end
      granted++;
      wait_idle();

      // Flush coincident with the response: refetch next cycle, no drain.
      lat = 1;
      exp_req.push_back(32'h280); exp_req.push_back(32'h200); exp_req.push_back(32'h204);
      push_dec(32'h13, 32'h200, 1'b0);
      do_flush(32'h280);
      wait_req(32'h280);
      @(negedge clk_in);
      flush_valid = 1'b1;
      flush_pc    = 32'h200;
      @(negedge clk_in);
      flush_valid = 1'b0;
      chk("coinc_req_low", {31'd0, ic_req_valid}, 32'd0);
      chk("coinc_dec_valid", {31'd0, dec_valid}, 32'd0);
      @(negedge clk_in);
      chk("coinc_req_valid", {31'd0, ic_req_valid}, 32'd1);
      chk("coinc_req_addr", ic_req_addr, 32'h200);
      granted++;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
